// File: rtl/midi_encoder_pkg.sv
// midi_encoder_pkg: MIDI command codes, encoder states and the status/length lookup
package midi_encoder_pkg;
  localparam int MIDI_CMD_SIZE = 3;
  typedef enum logic [MIDI_CMD_SIZE-1:0] {
    NOTE_OFF, NOTE_ON, POLY_AT, CTRL_CHG, PROG_CHG, CH_PRESSURE, PITCH_BEND, MIDI_SYSTEM
  } midi_cmd_t;
  typedef enum logic [2:0] {IDLE, SEND_STATUS, SEND_D0, SEND_D1, WAIT_TX} enc_state_t;
  typedef struct packed {
    logic [7:0] status;
    logic [1:0] len;
    logic       chan;
  } cmd_info_t;
  function automatic cmd_info_t cmd_info(input logic [MIDI_CMD_SIZE-1:0] cmd, input logic [3:0] ch);
    cmd_info_t r;
    r.chan   = cmd != MIDI_SYSTEM;
    r.status = r.chan ? {4'h8 + {1'b0, cmd}, ch} : {4'hF, ch};
    r.len    = !r.chan ? 2'd1 : (cmd == PROG_CHG || cmd == CH_PRESSURE) ? 2'd2 : 2'd3;
    return r;
  endfunction
endpackage

// File: rtl/midi_encoder.sv
// midi_encoder: serialises one decoded MIDI event into status/data bytes for uart_tx
module midi_encoder
  import midi_encoder_pkg::*;
#(
  parameter bit          RUNNING_STATUS    = 1'b1,
  parameter logic [31:0] RS_REFRESH_CYCLES = 32'd10_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     midi_rdy,
  input  logic [MIDI_CMD_SIZE-1:0] midi_cmd,
  input  logic [3:0]               midi_ch_sysn,
  input  logic [6:0]               midi_data0,
  input  logic [6:0]               midi_data1,
  output logic                     midi_busy,
  output logic                     err_dropped,
  input  logic                     tx_busy,
  output logic [7:0]               data_out,
  output logic                     data_out_rdy
);
  enc_state_t  state, state_n, ret, ret_n;
  cmd_info_t   info;
  logic [7:0]  status, rs, byte_n;
  logic [1:0]  len;
  logic [6:0]  d0, d1;
  logic [31:0] rs_cnt;
  logic        rs_valid, skip, fire, last, accept;
  assign info      = cmd_info(midi_cmd, midi_ch_sysn);
  assign skip      = RUNNING_STATUS && info.chan && rs_valid && rs == info.status;
  assign midi_busy = state != IDLE;
  assign accept    = state == IDLE && midi_rdy;
  assign fire      = state inside {SEND_STATUS, SEND_D0, SEND_D1} && !tx_busy;
  always_comb begin
    byte_n  = state == SEND_STATUS ? status : state == SEND_D0 ? {1'b0, d0} : {1'b0, d1};
    last    = state == SEND_STATUS ? len == 2'd1 : state == SEND_D0 ? len == 2'd2 : 1'b1;
    state_n = accept ? (skip ? SEND_D0 : SEND_STATUS) :
              fire ? (last ? IDLE : WAIT_TX) :
              state == WAIT_TX ? ret : state;
    ret_n   = fire ? (state == SEND_STATUS ? SEND_D0 : SEND_D1) : ret;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state        <= IDLE;
      ret          <= IDLE;
      data_out     <= 8'h00;
      data_out_rdy <= 1'b0;
      err_dropped  <= 1'b0;
      status       <= 8'h00;
      len          <= 2'd0;
      d0           <= 7'd0;
      d1           <= 7'd0;
      rs           <= 8'h00;
      rs_valid     <= 1'b0;
      rs_cnt       <= 32'd0;
    end else begin
      state        <= state_n;
      ret          <= ret_n;
      data_out_rdy <= fire;
      err_dropped  <= midi_rdy && midi_busy;
      if (fire) data_out <= byte_n;
      if (accept) begin
        status <= info.status;
        len    <= info.len;
        d0     <= midi_data0;
        d1     <= midi_data1;
      end
      // real-time status (F8-FF) keeps the register; F0-F7 kills it
      if (fire && state == SEND_STATUS) begin
        rs_cnt <= 32'd0;
        if (status[7:4] != 4'hF) begin
          rs       <= status;
          rs_valid <= 1'b1;
        end else if (!status[3]) rs_valid <= 1'b0;
      end else if (rs_valid) begin
        rs_cnt <= rs_cnt == RS_REFRESH_CYCLES - 1 ? 32'd0 : rs_cnt + 1;
        if (rs_cnt == RS_REFRESH_CYCLES - 1) rs_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_midi_encoder.sv
// tb_midi_encoder: directed table, corner sequences and a randomized run against a stream model
module tb_midi_encoder;
  localparam int R = 16;
  typedef struct {
    logic [2:0] cmd;
    logic [3:0] ch;
    logic [6:0] d0, d1;
    int         n;
    logic [7:0] b[3];
  } vec_t;
  typedef struct packed {
    logic [7:0] b;
    logic       st;
  } qb_t;
  logic clk = 0, reset = 1, rdy1 = 0, rdy0 = 0, tx_busy = 0, sel = 0;
  logic [2:0] cmd = 0;
  logic [3:0] ch = 0;
  logic [6:0] d0 = 0, d1 = 0;
  logic busy1, err1, ordy1, busy0, err0, ordy0, s_rdy, s_busy;
  logic [7:0] do1, do0, s_do;
  int passed = 0, total = 0, cyc = 0;
  assign s_rdy  = sel ? ordy0 : ordy1;
  assign s_busy = sel ? busy0 : busy1;
  assign s_do   = sel ? do0 : do1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  midi_encoder #(.RUNNING_STATUS(1'b1), .RS_REFRESH_CYCLES(32'(R))) u1 (
    .clk(clk), .reset(reset), .midi_rdy(rdy1), .midi_cmd(cmd), .midi_ch_sysn(ch),
    .midi_data0(d0), .midi_data1(d1), .midi_busy(busy1), .err_dropped(err1),
    .tx_busy(tx_busy), .data_out(do1), .data_out_rdy(ordy1));
  midi_encoder #(.RUNNING_STATUS(1'b0)) u0 (
    .clk(clk), .reset(reset), .midi_rdy(rdy0), .midi_cmd(cmd), .midi_ch_sysn(ch),
    .midi_data0(d0), .midi_data1(d1), .midi_busy(busy0), .err_dropped(err0),
    .tx_busy(tx_busy), .data_out(do0), .data_out_rdy(ordy0));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic vec_t mk(int c, int h, int a, int b, int n, int b0, int b1, int b2);
    vec_t v;
    v.cmd = 3'(c); v.ch = 4'(h); v.d0 = 7'(a); v.d1 = 7'(b); v.n = n;
    v.b[0] = 8'(b0); v.b[1] = 8'(b1); v.b[2] = 8'(b2);
    return v;
  endfunction
  task automatic drive(input vec_t v);
    cmd = v.cmd; ch = v.ch; d0 = v.d0; d1 = v.d1;
    if (sel) rdy0 = 1; else rdy1 = 1;
    @(negedge clk);
    rdy0 = 0; rdy1 = 0;
  endtask
  task automatic expect_msg(input vec_t v, input int t_first, input string tag);
    int got = 0, k = 0, last_t = 0;
    while (got < v.n && k < 2000) begin
      if (s_rdy) begin
        check({tag, "_byte"}, 32'(s_do), 32'(v.b[got]));
        check({tag, "_time"}, 32'(cyc), 32'(got == 0 ? t_first : last_t + 2));
        last_t = cyc;
        got++;
        check({tag, "_busy"}, 32'(s_busy), 32'(got < v.n));
      end
      if (got < v.n) begin @(negedge clk); k++; end
    end
    if (got < v.n) begin total++; $display("FAIL %s timeout: %0d of %0d bytes", tag, got, v.n); end
  endtask
  task automatic send(input vec_t v, input string tag);
    int t0 = cyc;
    drive(v);
    expect_msg(v, t0 + 2, tag);
  endtask
  vec_t tbl[16];
  vec_t v;
  qb_t q[$];
  qb_t e;
  logic [7:0] st, m_rs;
  logic m_valid, exp_err, prev_txb;
  int m_t, sent, strobes, tf, n, k;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0]  = mk(1, 2, 'h3C, 'h64, 3, 'h92, 'h3C, 'h64);
    tbl[1]  = mk(1, 2, 'h3C, 'h64, 2, 'h3C, 'h64, 0);
    tbl[2]  = mk(4, 0, 'h05, 0, 2, 'hC0, 'h05, 0);
    tbl[3]  = mk(7, 8, 0, 0, 1, 'hF8, 0, 0);
    tbl[4]  = mk(1, 0, 'h40, 'h7F, 3, 'h90, 'h40, 'h7F);
    tbl[5]  = mk(5, 0, 'h10, 0, 2, 'hD0, 'h10, 0);
    tbl[6]  = mk(1, 0, 'h40, 'h7F, 3, 'h90, 'h40, 'h7F);
    tbl[7]  = mk(7, 2, 0, 0, 1, 'hF2, 0, 0);
    tbl[8]  = mk(1, 0, 'h40, 'h7F, 3, 'h90, 'h40, 'h7F);
    tbl[9]  = mk(3, 5, 'h07, 'h55, 3, 'hB5, 'h07, 'h55);
    tbl[10] = mk(3, 5, 'h0A, 'h22, 2, 'h0A, 'h22, 0);
    tbl[11] = mk(7, 15, 0, 0, 1, 'hFF, 0, 0);
    tbl[12] = mk(3, 5, 'h01, 'h02, 2, 'h01, 'h02, 0);
    tbl[13] = mk(2, 15, 'h7F, 'h00, 3, 'hAF, 'h7F, 'h00);
    tbl[14] = mk(6, 15, 'h00, 'h40, 3, 'hEF, 'h00, 'h40);
    tbl[15] = mk(6, 15, 'h11, 'h22, 2, 'h11, 'h22, 0);
    repeat (2) @(negedge clk);
    check("rst_data_out", 32'(do1), 0);
    check("rst_data_rdy", 32'(ordy1), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_err", 32'(err1), 0);
    reset = 0;
    @(negedge clk);
    sel = 1;
    send(tbl[0], "rs0_first");
    send(tbl[0], "rs0_repeat");
    sel = 0;
    for (int i = 0; i < 16; i++) send(tbl[i], $sformatf("tbl%0d", i));
    v = mk(1, 1, 'h3C, 'h40, 3, 'h91, 'h3C, 'h40);
    send(v, "refresh_a");
    repeat (20) @(negedge clk);
    send(v, "refresh_b");
    v = mk(0, 4, 'h11, 'h22, 3, 'h84, 'h11, 'h22);
    tx_busy = 1;
    drive(v);
    strobes = 0;
    for (int j = 0; j < 500; j++) begin
      if (ordy1) strobes++;
      if (j == 101) check("drop_err", 32'(err1), 1);
      if (j == 102) check("drop_err_clear", 32'(err1), 0);
      rdy1 = 0;
      if (j == 100) begin cmd = 1; ch = 6; d0 = 7'h55; d1 = 7'h66; rdy1 = 1; end
      @(negedge clk);
    end
    check("hold_strobes", 32'(strobes), 0);
    check("hold_busy", 32'(busy1), 1);
    tx_busy = 0;
    tf = cyc;
    expect_msg(v, tf + 1, "txb");
    strobes = 0;
    repeat (30) begin @(negedge clk); if (ordy1) strobes++; end
    check("drop_absent", 32'(strobes), 0);
    v = mk(3, 3, 'h07, 'h10, 3, 'hB3, 'h07, 'h10);
    drive(v);
    k = 0;
    while (!ordy1 && k < 100) begin @(negedge clk); k++; end
    check("mid_first", 32'(do1), 'hB3);
    reset = 1;
    #1;
    check("mid_rst_data", 32'(do1), 0);
    check("mid_rst_rdy", 32'(ordy1), 0);
    check("mid_rst_busy", 32'(busy1), 0);
    check("mid_rst_err", 32'(err1), 0);
    @(negedge clk);
    check("mid_rst_hold", 32'(busy1), 0);
    reset = 0;
    send(v, "after_rst");
    send(mk(1, 3, 'h30, 'h31, 3, 'h93, 'h30, 'h31), "note_ch3");
    reset = 1;
    @(negedge clk);
    reset = 0;
    m_valid = 0; m_rs = 0; m_t = 0; exp_err = 0; prev_txb = 0; sent = 0;
    for (int c = 0; c < 8000 && (sent < 200 || q.size() != 0); c++) begin
      if (ordy1) begin
        if (q.size() == 0) begin total++; $display("FAIL rnd_extra: byte %0h with nothing pending", do1); end
        else begin
          e = q.pop_front();
          check("rnd_byte", 32'(do1), 32'(e.b));
          check("rnd_txb", 32'(prev_txb), 0);
          if (e.st) begin
            if (e.b[7:4] != 4'hF) begin m_valid = 1; m_rs = e.b; m_t = cyc; end
            else if (!e.b[3]) m_valid = 0;
            else if (m_valid && cyc <= m_t + R) m_t = cyc;
            else m_valid = 0;
          end
        end
      end
      check("rnd_err", 32'(err1), 32'(exp_err));
      check("rnd_busy", 32'(busy1), 32'(q.size() != 0));
      exp_err = 0;
      rdy1 = 0;
      if (sent < 200 && $urandom_range(0, 3) == 0) begin
        cmd = 3'($urandom_range(0, 7));
        ch = cmd == 3'd7 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
        d0 = 7'($urandom);
        d1 = 7'($urandom);
        rdy1 = 1;
        if (q.size() != 0) exp_err = 1;
        else begin
          st = cmd == 3'd7 ? 8'(8'hF0 + ch) : 8'(128 + 16 * int'(cmd) + int'(ch));
          n = cmd == 3'd7 ? 1 : (cmd == 3'd4 || cmd == 3'd5) ? 2 : 3;
          if (!(cmd != 3'd7 && m_valid && m_rs == st && cyc + 1 <= m_t + R)) q.push_back('{st, 1'b1});
          if (n > 1) q.push_back('{{1'b0, d0}, 1'b0});
          if (n > 2) q.push_back('{{1'b0, d1}, 1'b0});
          sent++;
        end
      end
      tx_busy = $urandom_range(0, 2) == 0;
      prev_txb = tx_busy;
      @(negedge clk);
    end
    rdy1 = 0;
    if (q.size() != 0) begin total++; $display("FAIL rnd_timeout: %0d bytes still pending", q.size()); end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
